// File: rtl/plotter_pkg.sv
// Shared types and default constants for the plotter motion sequencer.
package plotter_pkg;

    // Width of a single-axis step count (magnitude of a 16-bit signed move).
    localparam int STEP_W = 16;

    localparam int DEF_STEP_PERIOD = 1000;
    localparam int DEF_PULSE_WIDTH = 100;
    localparam int DEF_PEN_SETTLE  = 25_000_000;
    localparam int DEF_DIR_SETUP   = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PEN,
        ST_DIR,
        ST_PULSE,
        ST_GAP,
        ST_DONE
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/interval_timer.sv
// Loadable down-counter with a zero flag; one instance serves every wait
// in the sequencer (pen settle, direction setup, pulse high, pulse gap).
module interval_timer
#(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Load wins; otherwise count down and park at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/plotter_motion_sequencer.sv
// Two-axis pen plotter motion sequencer: accepts one relative move, drives
// the pen servo, sets direction lines, then emits Bresenham-interpolated
// step pulses on X and Y.
module plotter_motion_sequencer
    import plotter_pkg::*;
#(
    parameter int STEP_PERIOD = DEF_STEP_PERIOD,
    parameter int PULSE_WIDTH = DEF_PULSE_WIDTH,
    parameter int PEN_SETTLE  = DEF_PEN_SETTLE,
    parameter int DIR_SETUP   = DEF_DIR_SETUP
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [STEP_W-1:0] i_cmd_dx,
    input  logic [STEP_W-1:0] i_cmd_dy,
    input  logic              i_cmd_pen,
    input  logic              i_abort,
    output logic              o_step_x,
    output logic              o_step_y,
    output logic              o_dir_x,
    output logic              o_dir_y,
    output logic              o_pen_down,
    output logic              o_busy,
    output logic              o_done
);

    // Timer holds the longest wait; DIR_SETUP folded in so odd parameter
    // sets never truncate a load value.
    localparam int TMR_W = $clog2(max_int(max_int(PEN_SETTLE, STEP_PERIOD), DIR_SETUP) + 1);

    // A load of N makes the state exit N+1 edges later, hence the -1 on
    // waits that begin on a state transition rather than on accept.
    localparam logic [TMR_W-1:0] LD_PEN       = TMR_W'(PEN_SETTLE);
    localparam logic [TMR_W-1:0] LD_DIR_ACC   = TMR_W'(DIR_SETUP);
    localparam logic [TMR_W-1:0] LD_DIR_PEN   = TMR_W'(DIR_SETUP - 1);
    localparam logic [TMR_W-1:0] LD_PULSE     = TMR_W'(PULSE_WIDTH - 1);
    localparam logic [TMR_W-1:0] LD_GAP       = TMR_W'(STEP_PERIOD - PULSE_WIDTH - 1);

    state_t            r_state, w_state_n;

    logic [STEP_W-1:0] r_major, w_major_n;
    logic [STEP_W-1:0] r_minor, w_minor_n;
    logic              r_x_major, w_x_major_n;
    logic [STEP_W:0]   r_err, w_err_n;
    logic [STEP_W-1:0] r_rem, w_rem_n;

    logic              r_step_x, w_step_x_n;
    logic              r_step_y, w_step_y_n;
    logic              r_dir_x, w_dir_x_n;
    logic              r_dir_y, w_dir_y_n;
    logic              r_pen_down, w_pen_n;
    logic              r_busy, w_busy_n;
    logic              r_done, w_done_n;
    logic              r_cmd_ready, w_ready_n;

    logic              w_tmr_load;
    logic [TMR_W-1:0]  w_tmr_val;
    logic              w_tmr_zero;

    logic              w_accept;
    logic              w_abortable;
    logic              w_take_step;
    logic [STEP_W-1:0] w_abs_dx, w_abs_dy, w_new_major;
    logic              w_new_x_major;
    logic [STEP_W:0]   w_t;
    logic              w_minor_hit;

    interval_timer #(.W(TMR_W)) u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

    // Magnitudes as unsigned; -32768 maps to 32768 naturally in 16 bits.
    assign w_abs_dx      = i_cmd_dx[STEP_W-1] ? (~i_cmd_dx + STEP_W'(1)) : i_cmd_dx;
    assign w_abs_dy      = i_cmd_dy[STEP_W-1] ? (~i_cmd_dy + STEP_W'(1)) : i_cmd_dy;
    assign w_new_x_major = (w_abs_dx >= w_abs_dy);
    assign w_new_major   = w_new_x_major ? w_abs_dx : w_abs_dy;

    assign w_accept    = (r_state == ST_IDLE) && i_cmd_valid && r_cmd_ready;
    assign w_abortable = (r_state != ST_IDLE) && (r_state != ST_DONE);

    // Bresenham trial sum for the next major step.
    assign w_t         = r_err + {1'b0, r_minor};
    assign w_minor_hit = (w_t >= {1'b0, r_major});

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next-state, timer control and next values for every registered output.
    always_comb begin
        w_state_n   = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        w_take_step = 1'b0;
        w_major_n   = r_major;
        w_minor_n   = r_minor;
        w_x_major_n = r_x_major;
        w_err_n     = r_err;
        w_rem_n     = r_rem;
        w_step_x_n  = r_step_x;
        w_step_y_n  = r_step_y;
        w_dir_x_n   = r_dir_x;
        w_dir_y_n   = r_dir_y;
        w_pen_n     = r_pen_down;
        w_done_n    = 1'b0;

        if (w_abortable && i_abort) begin
            // Abort keeps pen and direction, drops any pulse in flight.
            w_state_n  = ST_DONE;
            w_step_x_n = 1'b0;
            w_step_y_n = 1'b0;
            w_done_n   = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_x_major_n = w_new_x_major;
                        w_major_n   = w_new_major;
                        w_minor_n   = w_new_x_major ? w_abs_dy : w_abs_dx;
                        w_err_n     = {2'b00, w_new_major[STEP_W-1:1]};
                        w_rem_n     = w_new_major;
                        w_dir_x_n   = ~i_cmd_dx[STEP_W-1];
                        w_dir_y_n   = ~i_cmd_dy[STEP_W-1];
                        w_pen_n     = i_cmd_pen;
                        w_tmr_load  = 1'b1;
                        if (i_cmd_pen != r_pen_down) begin
                            w_state_n = ST_PEN;
                            w_tmr_val = LD_PEN;
                        end else begin
                            w_state_n = ST_DIR;
                            w_tmr_val = LD_DIR_ACC;
                        end
                    end
                end
                ST_PEN: begin
                    if (w_tmr_zero) begin
                        w_state_n  = ST_DIR;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = LD_DIR_PEN;
                    end
                end
                ST_DIR: begin
                    if (w_tmr_zero) begin
                        if (r_rem == '0) begin
                            w_state_n = ST_DONE;
                            w_done_n  = 1'b1;
                        end else begin
                            w_take_step = 1'b1;
                        end
                    end
                end
                ST_PULSE: begin
                    if (w_tmr_zero) begin
                        w_state_n  = ST_GAP;
                        w_step_x_n = 1'b0;
                        w_step_y_n = 1'b0;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = LD_GAP;
                    end
                end
                ST_GAP: begin
                    if (w_tmr_zero) begin
                        if (r_rem == '0) begin
                            w_state_n = ST_DONE;
                            w_done_n  = 1'b1;
                        end else begin
                            w_take_step = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    w_state_n = ST_IDLE;
                end
                default: begin
                    w_state_n = ST_IDLE;
                end
            endcase
        end

        // One major step: major axis always pulses, minor pulses on overflow.
        if (w_take_step) begin
            w_state_n  = ST_PULSE;
            w_tmr_load = 1'b1;
            w_tmr_val  = LD_PULSE;
            w_rem_n    = r_rem - STEP_W'(1);
            w_err_n    = w_minor_hit ? (w_t - {1'b0, r_major}) : w_t;
            w_step_x_n = r_x_major | w_minor_hit;
            w_step_y_n = ~r_x_major | w_minor_hit;
        end

        w_busy_n  = (w_state_n != ST_IDLE);
        w_ready_n = (w_state_n == ST_IDLE);
    end

    // Move datapath and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_major     <= '0;
            r_minor     <= '0;
            r_x_major   <= 1'b0;
            r_err       <= '0;
            r_rem       <= '0;
            r_step_x    <= 1'b0;
            r_step_y    <= 1'b0;
            r_dir_x     <= 1'b0;
            r_dir_y     <= 1'b0;
            r_pen_down  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cmd_ready <= 1'b0;
        end else begin
            r_major     <= w_major_n;
            r_minor     <= w_minor_n;
            r_x_major   <= w_x_major_n;
            r_err       <= w_err_n;
            r_rem       <= w_rem_n;
            r_step_x    <= w_step_x_n;
            r_step_y    <= w_step_y_n;
            r_dir_x     <= w_dir_x_n;
            r_dir_y     <= w_dir_y_n;
            r_pen_down  <= w_pen_n;
            r_busy      <= w_busy_n;
            r_done      <= w_done_n;
            r_cmd_ready <= w_ready_n;
        end
    end

    assign o_cmd_ready = r_cmd_ready;
    assign o_step_x    = r_step_x;
    assign o_step_y    = r_step_y;
    assign o_dir_x     = r_dir_x;
    assign o_dir_y     = r_dir_y;
    assign o_pen_down  = r_pen_down;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_plotter_motion_sequencer.sv
// Directed + randomized bench for plotter_motion_sequencer. Expected
// waveforms come from the ideal-line step schedule computed per command.
module tb_plotter_motion_sequencer;

    localparam int SP = 8;
    localparam int PW = 3;
    localparam int PS = 20;
    localparam int DS = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_dx = '0;
    logic [15:0] cmd_dy = '0;
    logic        cmd_pen = 1'b0;
    logic        abort = 1'b0;
    logic        step_x, step_y, dir_x, dir_y, pen_down, busy, done;

    int checks = 0;
    int failures = 0;
    bit cur_pen = 1'b0;

    // Per-cycle expectation {ready, busy, done, step_y, step_x}.
    logic [4:0] expw [0:255];

    plotter_motion_sequencer #(
        .STEP_PERIOD (SP),
        .PULSE_WIDTH (PW),
        .PEN_SETTLE  (PS),
        .DIR_SETUP   (DS)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_dx    (cmd_dx),
        .i_cmd_dy    (cmd_dy),
        .i_cmd_pen   (cmd_pen),
        .i_abort     (abort),
        .o_step_x    (step_x),
        .o_step_y    (step_y),
        .o_dir_x     (dir_x),
        .o_dir_y     (dir_y),
        .o_pen_down  (pen_down),
        .o_busy      (busy),
        .o_done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", name, obs, exp);
            $error("check %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [7:0] all_outs();
        return {cmd_ready, busy, done, step_y, step_x, dir_y, dir_x, pen_down};
    endfunction

    // abort_req: -1 none, -2 random chance, >=1 offset of the edge that samples abort.
    task automatic run_cmd(input int dx, input int dy, input bit pen, input int abort_req, input string tag);
        int  adx, ady, maj, mnr, h, base, dn, last, r, abort_at, xr, yr;
        bit  xmaj, pc, ms, xs, ys, px, py;
        adx  = (dx < 0) ? -dx : dx;
        ady  = (dy < 0) ? -dy : dy;
        xmaj = (adx >= ady);
        maj  = xmaj ? adx : ady;
        mnr  = xmaj ? ady : adx;
        h    = maj / 2;
        pc   = (pen != cur_pen);
        base = (pc ? PS : 0) + DS + 1;
        dn   = base + maj * SP;
        abort_at = abort_req;
        if (abort_req == -2)
            abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, dn)) : -1;
        last = (abort_at >= 0) ? abort_at : dn;

        for (int c = 0; c <= last; c++) expw[c] = 5'b01000;
        for (int k = 0; k < maj; k++) begin
            r  = base + k * SP;
            // Minor axis steps whenever the ideal line crosses a new integer.
            ms = (((k + 1) * mnr + h) / maj) > ((k * mnr + h) / maj);
            xs = xmaj || ms;
            ys = !xmaj || ms;
            for (int p = 0; p < PW; p++) begin
                if (r + p < last) begin
                    if (xs) expw[r + p][0] = 1'b1;
                    if (ys) expw[r + p][1] = 1'b1;
                end
            end
        end
        expw[last][2] = 1'b1;

        @(negedge clk);
        for (int w = 0; w < 200 && !cmd_ready; w++) @(negedge clk);
        check($sformatf("%s_ready_before", tag), cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_dx    = 16'(dx);
        cmd_dy    = 16'(dy);
        cmd_pen   = pen;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_dx    = 16'($urandom);
        cmd_dy    = 16'($urandom);
        cmd_pen   = 1'($urandom);
        cur_pen   = pen;

        xr = 0; yr = 0; px = 0; py = 0;
        for (int c = 0; c <= last + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check($sformatf("%s_dir_x", tag), dir_x, (dx >= 0) ? 1 : 0);
                check($sformatf("%s_dir_y", tag), dir_y, (dy >= 0) ? 1 : 0);
                check($sformatf("%s_pen", tag), pen_down, pen);
            end
            if (c <= last)
                check($sformatf("%s_wave@%0d", tag, c), {cmd_ready, busy, done, step_y, step_x}, expw[c]);
            else
                check($sformatf("%s_idle_after", tag), {cmd_ready, busy, done, step_y, step_x}, 5'b10000);
            if (step_x && !px) xr++;
            if (step_y && !py) yr++;
            px = step_x;
            py = step_y;
            if (abort_at >= 1 && c == abort_at - 1) abort = 1'b1;
            if (c == abort_at) abort = 1'b0;
        end
        if (abort_at < 0) begin
            check($sformatf("%s_x_pulses", tag), xr, adx);
            check($sformatf("%s_y_pulses", tag), yr, ady);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dx, dy;
        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_outs", all_outs(), 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {cmd_ready, busy}, 2'b10);

        run_cmd(5, 0, 1'b0, -1, "x5");
        run_cmd(-4, 2, 1'b1, -1, "diag_pen");
        run_cmd(3, -7, 1'b1, -1, "ymajor");
        run_cmd(0, 0, 1'b1, -1, "zero");
        run_cmd(10, 0, 1'b1, 13, "abort");
        check("abort_pen_kept", pen_down, 1);
        run_cmd(3, -3, 1'b0, -1, "tie");
        run_cmd(0, 0, 1'b1, -1, "zero_pen");

        // Reset during GAP of a pen-changing move.
        @(negedge clk);
        for (int w = 0; w < 200 && !cmd_ready; w++) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_dx    = 16'(3);
        cmd_dy    = 16'(1);
        cmd_pen   = ~cur_pen;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (PS + DS + 1 + PW + 2) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_outs", all_outs(), 8'h00);
        cur_pen = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_midreset", {cmd_ready, busy}, 2'b10);
        run_cmd(2, -1, 1'b1, -1, "post_reset");

        // Randomized moves, some aborted at a random point.
        for (int n = 0; n < 10; n++) begin
            dx = int'($urandom_range(0, 12)) - 6;
            dy = int'($urandom_range(0, 12)) - 6;
            run_cmd(dx, dy, 1'($urandom), -2, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
